// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryptor register block.
//   - Word addresses of the Avalon register map.
//   - Bit positions inside the CTRL and STATUS words.
//   - Run sequencer state encoding.
package aes_pkg;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_ENC0   = 4'd4;
  localparam logic [3:0] ADDR_DEC0   = 4'd8;
  localparam logic [3:0] ADDR_RSVD0  = 4'd12;
  localparam logic [3:0] ADDR_CTRL   = 4'd14;
  localparam logic [3:0] ADDR_STATUS = 4'd15;

  // CTRL write: start request bit.
  localparam int CTRL_START_BIT = 0;

  // STATUS layout: {count[31:16], 13'b0, 0, BUSY, DONE}.
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_CNT_LSB  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/avl_word_reg.sv
// One 32-bit software-writable register with per-byte write enables.
//   CLK        system clock
//   RESET      synchronous active-high reset, clears the word
//   we_i       write strobe (already address-decoded)
//   inhibit_i  blocks the write when high (register frozen)
//   be_i       byte enables for wdata_i
//   wdata_i    write data
//   q_o        current register value
module avl_word_reg (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        we_i,
  input  logic        inhibit_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);

  logic [31:0] word_q;

  // NOTE: sequential state is always assigned with <= so every register in
  // the design samples pre-edge values, regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_q <= '0;
    end else if (we_i && !inhibit_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) word_q[8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file and run sequencer for the AES-128 decryptor.
//   CLK, RESET              clock, synchronous active-high reset
//   AVL_CS/READ/WRITE       Avalon slave strobes (READ/WRITE qualified by CS)
//   AVL_ADDR, AVL_BYTE_EN   word address, write byte enables
//   AVL_WRITEDATA           write data
//   AVL_READDATA            read data, loaded one cycle after the read strobe
//   AES_KEY, AES_MSG_ENC    key and ciphertext to the core (word 0/4 on top)
//   AES_START               run request, high for the whole run
//   AES_DONE, AES_MSG_DEC   core completion and plaintext
// Map: 0-3 KEY, 4-7 MSG_ENC, 8-11 MSG_DEC (RO), 12-13 reserved, 14 CTRL,
// 15 STATUS.
module aes_avalon_regs
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  output logic         AES_START,
  input  logic         AES_DONE,
  input  logic [127:0] AES_MSG_DEC
);

  logic wr_en;
  logic rd_en;
  logic busy;
  logic start_req;
  logic done_clr;

  assign wr_en = AVL_CS & AVL_WRITE;
  assign rd_en = AVL_CS & AVL_READ;

  assign start_req = wr_en && (AVL_ADDR == ADDR_CTRL) &&
                     AVL_BYTE_EN[0] && AVL_WRITEDATA[CTRL_START_BIT];
  assign done_clr  = wr_en && (AVL_ADDR == ADDR_STATUS) &&
                     AVL_BYTE_EN[0] && AVL_WRITEDATA[STAT_DONE_BIT];

  // ---------------------------------------------------------------------------
  // Key and ciphertext words; frozen while a run is in progress so the core
  // sees stable operands.
  // ---------------------------------------------------------------------------
  logic [31:0] word_q [8];

  for (genvar i = 0; i < 8; i++) begin : g_word
    avl_word_reg u_word (
      .CLK       (CLK),
      .RESET     (RESET),
      .we_i      (wr_en && (AVL_ADDR == 4'(i))),
      .inhibit_i (busy),
      .be_i      (AVL_BYTE_EN),
      .wdata_i   (AVL_WRITEDATA),
      .q_o       (word_q[i])
    );
  end

  assign AES_KEY     = {word_q[0], word_q[1], word_q[2], word_q[3]};
  assign AES_MSG_ENC = {word_q[4], word_q[5], word_q[6], word_q[7]};

  // ---------------------------------------------------------------------------
  // Run sequencer
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  assign busy = (state_q == RUN);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    AES_START = 1'b0;

    if (done_clr) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A start wins over a same-cycle DONE clear; both clear DONE anyway.
        if (start_req) begin
          state_d = RUN;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        AES_START = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (AES_DONE) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Plaintext capture; AES_DONE outside RUN never reaches here.
  // ---------------------------------------------------------------------------
  logic [31:0] dec_q [4];

  // NOTE: this small array is reset explicitly because software must read 0
  // from the plaintext words after reset; it maps to flops, not RAM.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int w = 0; w < 4; w++) dec_q[w] <= '0;
    end else if (capture) begin
      for (int w = 0; w < 4; w++) dec_q[w] <= AES_MSG_DEC[127-32*w -: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered, built from pre-edge state so a same-cycle write
  // returns the old value.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] rdata_q;

  always_comb begin
    rd_word = '0;
    if (AVL_ADDR < ADDR_DEC0) begin
      rd_word = word_q[AVL_ADDR[2:0]];
    end else if (AVL_ADDR < ADDR_RSVD0) begin
      rd_word = dec_q[AVL_ADDR[1:0]];
    end else if (AVL_ADDR == ADDR_CTRL) begin
      rd_word = {31'b0, busy};
    end else if (AVL_ADDR == ADDR_STATUS) begin
      rd_word[31:STAT_CNT_LSB]  = 16'(cnt_q);
      rd_word[STAT_BUSY_BIT]    = busy;
      rd_word[STAT_DONE_BIT]    = done_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_word;
    end
  end

  assign AVL_READDATA = rdata_q;

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Self-checking bench for aes_avalon_regs: stub decryptor with programmable
// latency, randomized register traffic, and a map-level reference model.
module tb_aes_avalon_regs;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         AVL_CS = 1'b0;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic [3:0]   AVL_ADDR = '0;
  logic [3:0]   AVL_BYTE_EN = '0;
  logic [31:0]  AVL_WRITEDATA = '0;
  logic [31:0]  AVL_READDATA;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;

  always #5 clk = ~clk;

  aes_avalon_regs #(.CNT_W(16)) dut (
    .CLK           (clk),
    .RESET         (RESET),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .AES_KEY       (AES_KEY),
    .AES_MSG_ENC   (AES_MSG_ENC),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .AES_MSG_DEC   (AES_MSG_DEC)
  );

  // Plaintext the stub core returns for a given key and ciphertext.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return k ^ {c[63:0], c[127:64]};
  endfunction

  // ---------------------------------------------------------------------------
  // Stub core: raises AES_DONE in the lat-th cycle of AES_START being high.
  // ---------------------------------------------------------------------------
  int           lat = 10;
  int           stub_cyc = 0;
  logic         stub_done = 1'b0;
  logic [127:0] stub_dec = '0;
  logic         inj_done = 1'b0;
  logic [127:0] inj_dec = '0;
  logic         prev_start = 1'b0;
  int           n_rises = 0;
  logic         sad_valid = 1'b0;
  logic         start_after_done = 1'b1;

  assign AES_DONE    = stub_done | inj_done;
  assign AES_MSG_DEC = inj_done ? inj_dec : stub_dec;

  always @(negedge clk) begin
    if (stub_done) begin
      start_after_done = AES_START;
      sad_valid = 1'b1;
    end
    if (AES_START && !prev_start) n_rises++;
    prev_start = AES_START;
    if (!AES_START) begin
      stub_cyc  = 0;
      stub_done = 1'b0;
    end else begin
      stub_cyc++;
      stub_done = (stub_cyc == lat);
      stub_dec  = core_fn(AES_KEY, AES_MSG_ENC);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model at register-map level
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [8];
  logic [31:0] m_dec  [4];
  logic        m_busy;
  logic        m_done;
  int          m_cnt;
  int          m_runs;

  function automatic logic [31:0] m_read(input int a);
    if (a < 8)   return m_regs[a];
    if (a < 12)  return m_dec[a-8];
    if (a == 14) return {31'b0, m_busy};
    if (a == 15) return {m_cnt[15:0], 13'b0, 1'b0, m_busy, m_done};
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    for (int i = 0; i < 4; i++) m_dec[i] = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic logic [127:0] m_key();
    return {m_regs[0], m_regs[1], m_regs[2], m_regs[3]};
  endfunction

  function automatic logic [127:0] m_enc();
    return {m_regs[4], m_regs[5], m_regs[6], m_regs[7]};
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus tasks: drive at a falling edge, the rising edge in between acts.
  // ---------------------------------------------------------------------------
  task automatic avl_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a;
    AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  // Bus write that also updates the model following the register map.
  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
    avl_wr(4'(a), d, be);
    if (a < 8 && !m_busy) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_regs[a][8*b +: 8] = d[8*b +: 8];
    end
    if (a == 15 && be[0] && d[0]) m_done = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a);
    logic [31:0] d;
    avl_rd(4'(a), d);
    check(tag, 128'(d), 128'(m_read(a)));
  endtask

  task automatic load_operands(input logic [127:0] k, input logic [127:0] c);
    for (int w = 0; w < 4; w++) begin
      bus_write(w,     k[127-32*w -: 32], 4'hF);
      bus_write(w + 4, c[127-32*w -: 32], 4'hF);
    end
  endtask

  task automatic start_run(input int l);
    lat = l;
    sad_valid = 1'b0;
    avl_wr(4'd14, 32'h1, 4'h1);
    m_busy = 1'b1;
    m_done = 1'b0;
    m_runs++;
  endtask

  // Poll STATUS until DONE, then check the outcome against the model.
  task automatic finish_run(input string tag, input int l);
    logic [31:0]  s;
    logic         got = 1'b0;
    logic [127:0] pt;
    for (int i = 0; i < 400 && !got; i++) begin
      avl_rd(4'd15, s);
      if (s[0]) got = 1'b1;
    end
    check({tag, "_done_seen"}, 128'(got), 128'(1));
    m_busy = 1'b0;
    m_done = 1'b1;
    m_cnt  = l;
    pt = core_fn(m_key(), m_enc());
    for (int w = 0; w < 4; w++) m_dec[w] = pt[127-32*w -: 32];
    check({tag, "_status"}, 128'(s), 128'(m_read(15)));
    for (int w = 0; w < 4; w++) read_check({tag, "_dec"}, 8 + w);
    check({tag, "_start_low_after_done"}, {126'b0, sad_valid, start_after_done}, 128'b10);
    check({tag, "_run_count"}, 128'(n_rises), 128'(m_runs));
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    m_runs = 0;
    m_reset();

    repeat (2) @(negedge clk);
    RESET = 1'b0;

    // Reset state.
    check("rst_start", 128'(AES_START), 128'(0));
    check("rst_rdata", 128'(AVL_READDATA), 128'(0));
    for (int a = 0; a < 16; a++) read_check("rst_read", a);

    // Byte enables.
    bus_write(0, 32'hFFFFFFFF, 4'b1111);
    bus_write(0, 32'h00000000, 4'b0101);
    avl_rd(4'd0, d);
    check("byte_en", 128'(d), 128'(32'hFF00FF00));

    // Random map traffic with no starts.
    for (int i = 0; i < 60; i++) begin
      int          a;
      logic [31:0] wd;
      a  = int'($urandom_range(0, 15));
      wd = $urandom;
      if (a == 14) wd[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) bus_write(a, wd, 4'($urandom_range(0, 15)));
      else read_check("rand_read", a);
    end
    check("rand_key", AES_KEY, m_key());
    check("rand_enc", AES_MSG_ENC, m_enc());

    // Read and write of the same word in one cycle.
    bus_write(1, 32'h11111111, 4'hF);
    @(negedge clk);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd1;
    AVL_WRITEDATA = 32'h22222222; AVL_BYTE_EN = 4'hF;
    @(negedge clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    check("rw_same_old", 128'(AVL_READDATA), 128'(32'h11111111));
    m_regs[1] = 32'h22222222;
    read_check("rw_same_new", 1);

    // Known-answer run.
    load_operands(FIPS_KEY, FIPS_CT);
    start_run(int'($urandom_range(2, 30)));
    finish_run("fips", lat);

    // Fixed 50-cycle run.
    start_run(50);
    finish_run("lat50", 50);
    read_check("lat50_ctrl", 14);

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      load_operands({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
      start_run(int'($urandom_range(2, 30)));
      finish_run("rand_run", lat);
    end

    // DONE clear in IDLE keeps count.
    bus_write(15, 32'h1, 4'h1);
    read_check("done_clr", 15);

    // AES_DONE while IDLE is ignored.
    @(negedge clk);
    inj_dec = {$urandom, $urandom, $urandom, $urandom};
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    read_check("idle_done_status", 15);
    read_check("idle_done_dec", 9);

    // Writes and starts are blocked during RUN.
    load_operands({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
    start_run(40);
    bus_write(4, 32'hDEADBEEF, 4'hF);
    avl_wr(4'd14, 32'h1, 4'h1);
    check("busy_enc_stable", AES_MSG_ENC, m_enc());
    read_check("busy_ctrl", 14);
    finish_run("busy", 40);
    read_check("busy_reg4", 4);

    // Reset at RUN cycle 10.
    start_run(100);
    repeat (9) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    m_reset();
    check("midrst_start", 128'(AES_START), 128'(0));
    check("midrst_rdata", 128'(AVL_READDATA), 128'(0));
    for (int a = 0; a < 16; a++) read_check("midrst_read", a);
    check("midrst_key", AES_KEY, 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
